dp_tap_ctrl: RTL and testbench
==============================

// Module: dp_tap_ctrl
//
// PURPOSE
//   IEEE 1149.1 TAP controller and instruction register for the debug port.
//   Runs the 16-state TAP FSM from TMS and shifts the 5-bit instruction in through TDI.
//   Drives ir_out straight into the debug instruction decoder, which turns it into a
//   boundary-scan register select.
//   Generates the capture/shift/update strobes for the selected DR and muxes TDO.
//   Sits between the JTAG pins (clk = TCK domain) and the IR decoder / DR chain.
//
// PARAMETERS
//   IR_W        5       instruction register width
//   IR_RESET    5'h01   IR value in Test-Logic-Reset (IDCODE)
//   IR_CAPTURE  5'h01   value loaded in Capture-IR; bits[1:0] must be 2'b01
//
// PORTS
//   clk         in   1     TCK; all state changes on the rising edge
//   resetn      in   1     synchronous, active-low reset
//   tms         in   1     test mode select, sampled on rising clk
//   tdi         in   1     serial data in, sampled on rising clk
//   dr_tdo      in   1     serial out of the currently selected DR
//   tdo         out  1     serial data out
//   tdo_en      out  1     1 while in Shift-IR or Shift-DR
//   ir_out      out  IR_W  current instruction, to the decoder
//   tlr         out  1     1 while in Test-Logic-Reset
//   dr_capture  out  1     1 while in Capture-DR
//   dr_shift    out  1     1 while in Shift-DR
//   dr_update   out  1     1 while in Update-DR
//
// BEHAVIOUR
//   Reset (resetn=0 at a rising edge), taking priority over everything:
//   - state <= TEST_LOGIC_RESET; ir_out <= IR_RESET; ir_sr <= 0.
//   - Outputs after reset: tlr=1; tdo_en, dr_*, tdo all 0.
//   - A scan in progress is discarded, with no partial IR update.
//
//   FSM: 4-bit state register; next state depends only on (state, tms).
//     tms=0 / tms=1 successors:
//     - TLR: RTI / TLR
//     - RTI: RTI / SEL_DR
//     - SEL_DR: CAP_DR / SEL_IR
//     - CAP_DR: SH_DR / EX1_DR
//     - SH_DR: SH_DR / EX1_DR
//     - EX1_DR: PAU_DR / UPD_DR
//     - PAU_DR: PAU_DR / EX2_DR
//     - EX2_DR: SH_DR / UPD_DR
//     - UPD_DR: RTI / SEL_DR
//     - SEL_IR: CAP_IR / TLR
//     - The IR column mirrors the DR column (CAP_IR..UPD_IR).
//   - Five consecutive tms=1 clocks reach TLR from any state.
//   - While in TLR: ir_out <= IR_RESET on every edge.
//
//   IR path (updates on the edge leaving the named state):
//   - CAP_IR: ir_sr <= IR_CAPTURE.
//   - SH_IR: ir_sr <= {tdi, ir_sr[IR_W-1:1]}, so shifting is LSB-first.
//   - UPD_IR: ir_out <= ir_sr.
//     - ir_out changes exactly one clock after entering UPD_IR.
//     - ir_out is stable at all other times, including during pauses.
//   - PAU_IR / EX1_IR / EX2_IR: ir_sr holds its value.
//
//   DR path: dr_capture, dr_shift and dr_update are decoded combinationally from the
//   state register. The DR acts on the same rising edge, so each is a 1-clock pulse per
//   state visit; dr_shift may stay high for N clocks.
//
//   TDO (combinational from registers):
//   - In SH_IR: tdo = ir_sr[0].
//   - In SH_DR: tdo = dr_tdo.
//   - Otherwise: tdo = 0.
//   - tdo_en = (state==SH_IR) | (state==SH_DR).
//
//   Simultaneous tms and tdi: tdi is shifted on the same edge on which tms=1 leaves
//   SH_IR/SH_DR; the last bit is taken on the exit edge.
//
// TESTING
//   1. Reset: resetn=0 for 2 clk
//      -> tlr=1, ir_out=5'h01, tdo_en=0, dr_*=0.
//   2. TMS=1 held for 5 clk from SH_DR
//      -> tlr=1, ir_out=5'h01.
//   3. IR load 5'h11 (DMI) from RTI:
//      tms 1,1,0,0; then 5 shifts tdi=1,0,0,0,1 with tms=1 on the last; then tms 1,0
//      -> tdo out = 1,0,0,0,0; ir_out=5'h11 one clk after UPD_IR.
//   4. DR scan, 8 bits, dr_tdo=8'hA5 pattern
//      -> dr_capture 1 clk, dr_shift 8 clk, dr_update 1 clk;
//         tdo mirrors dr_tdo only during SH_DR.
//   5. Pause mid IR shift:
//      shift 2 bits -> EX1 -> PAU x3 -> EX2 -> SH, shift 3 bits -> update
//      -> ir_out equals the 5 bits shifted, pause bits ignored.
//   6. resetn=0 mid SH_IR after 3 bits
//      -> ir_out=5'h01, state TLR, no update of the partial value.

Source files
------------

// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller with a 5-bit instruction register for the debug port.
// Decodes the DR capture/shift/update strobes and muxes TDO between the IR and the selected DR.
module dp_tap_ctrl #(
    parameter int              IR_W       = 5,
    parameter logic [IR_W-1:0] IR_RESET   = IR_W'(1),
    parameter logic [IR_W-1:0] IR_CAPTURE = IR_W'(1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            tms,
    input  logic            tdi,
    input  logic            dr_tdo,
    output logic            tdo,
    output logic            tdo_en,
    output logic [IR_W-1:0] ir_out,
    output logic            tlr,
    output logic            dr_capture,
    output logic            dr_shift,
    output logic            dr_update
);

    // Standard 1149.1 state encoding.
    localparam logic [3:0] S_EX2_DR = 4'h0;
    localparam logic [3:0] S_EX1_DR = 4'h1;
    localparam logic [3:0] S_SH_DR  = 4'h2;
    localparam logic [3:0] S_PAU_DR = 4'h3;
    localparam logic [3:0] S_SEL_IR = 4'h4;
    localparam logic [3:0] S_UPD_DR = 4'h5;
    localparam logic [3:0] S_CAP_DR = 4'h6;
    localparam logic [3:0] S_SEL_DR = 4'h7;
    localparam logic [3:0] S_EX2_IR = 4'h8;
    localparam logic [3:0] S_EX1_IR = 4'h9;
    localparam logic [3:0] S_SH_IR  = 4'hA;
    localparam logic [3:0] S_PAU_IR = 4'hB;
    localparam logic [3:0] S_RTI    = 4'hC;
    localparam logic [3:0] S_UPD_IR = 4'hD;
    localparam logic [3:0] S_CAP_IR = 4'hE;
    localparam logic [3:0] S_TLR    = 4'hF;

    logic [3:0]      state_q, state_d;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic [IR_W-1:0] ir_out_q, ir_out_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TLR:    state_d = tms ? S_TLR    : S_RTI;
            S_RTI:    state_d = tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: state_d = tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: state_d = tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  state_d = tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: state_d = tms ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: state_d = tms ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: state_d = tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: state_d = tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: state_d = tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: state_d = tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  state_d = tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: state_d = tms ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: state_d = tms ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: state_d = tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: state_d = tms ? S_SEL_DR : S_RTI;
            default:  state_d = S_TLR;
        endcase
    end

    // The last tdi bit is still taken on the edge that leaves Shift-IR.
    always_comb begin
        ir_sr_d  = ir_sr_q;
        ir_out_d = ir_out_q;
        case (state_q)
            S_CAP_IR: ir_sr_d  = IR_CAPTURE;
            S_SH_IR:  ir_sr_d  = {tdi, ir_sr_q[IR_W-1:1]};
            S_UPD_IR: ir_out_d = ir_sr_q;
            S_TLR:    ir_out_d = IR_RESET;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_TLR;
            ir_sr_q  <= '0;
            ir_out_q <= IR_RESET;
        end else begin
            state_q  <= state_d;
            ir_sr_q  <= ir_sr_d;
            ir_out_q <= ir_out_d;
        end
    end

    always_comb begin
        tlr        = (state_q == S_TLR);
        dr_capture = (state_q == S_CAP_DR);
        dr_shift   = (state_q == S_SH_DR);
        dr_update  = (state_q == S_UPD_DR);
        tdo_en     = (state_q == S_SH_IR) | (state_q == S_SH_DR);
        tdo        = 1'b0;
        if (state_q == S_SH_IR)
            tdo = ir_sr_q[0];
        else if (state_q == S_SH_DR)
            tdo = dr_tdo;
    end

    assign ir_out = ir_out_q;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Self-checking bench for dp_tap_ctrl: directed scans plus random TMS/TDI traffic
// compared against a column/phase model of the TAP.
module tb_dp_tap_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       dr_tdo = 1'b0;
    logic       tdo, tdo_en, tlr, dr_capture, dr_shift, dr_update;
    logic [4:0] ir_out;

    dp_tap_ctrl dut (
        .clk(clk), .resetn(resetn), .tms(tms), .tdi(tdi), .dr_tdo(dr_tdo),
        .tdo(tdo), .tdo_en(tdo_en), .ir_out(ir_out), .tlr(tlr),
        .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update)
    );

    always #5 clk = ~clk;

    // Model: TLR, RTI, or a phase inside the DR or IR column.
    localparam int K_TLR = 0, K_RTI = 1, K_COL = 2;
    localparam int P_SEL = 0, P_CAP = 1, P_SH = 2, P_EX1 = 3, P_PAU = 4, P_EX2 = 5, P_UPD = 6;

    int         m_kind = K_TLR;
    bit         m_ir   = 1'b0;
    int         m_ph   = P_SEL;
    logic [4:0] m_sr   = 5'h00;
    logic [4:0] m_out  = 5'h01;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic t, input logic d);
        if (!rn) begin
            m_kind = K_TLR; m_ir = 1'b0; m_ph = P_SEL; m_sr = 5'h00; m_out = 5'h01;
            return;
        end
        if (m_kind == K_TLR) m_out = 5'h01;
        if (m_kind == K_COL && m_ir) begin
            if (m_ph == P_CAP) m_sr = 5'h01;
            if (m_ph == P_SH)  m_sr = {d, m_sr[4:1]};
            if (m_ph == P_UPD) m_out = m_sr;
        end
        case (m_kind)
            K_TLR: if (!t) m_kind = K_RTI;
            K_RTI: if (t) begin m_kind = K_COL; m_ir = 1'b0; m_ph = P_SEL; end
            default: begin
                case (m_ph)
                    P_SEL: if (!t) m_ph = P_CAP;
                           else if (m_ir) m_kind = K_TLR;
                           else m_ir = 1'b1;
                    P_CAP, P_SH: m_ph = t ? P_EX1 : P_SH;
                    P_EX1: m_ph = t ? P_UPD : P_PAU;
                    P_PAU: m_ph = t ? P_EX2 : P_PAU;
                    P_EX2: m_ph = t ? P_UPD : P_SH;
                    default: if (t) begin m_ir = 1'b0; m_ph = P_SEL; end
                             else m_kind = K_RTI;
                endcase
            end
        endcase
    endtask

    task automatic cyc(input logic rn, input logic t, input logic d, input logic dt);
        bit in_col;
        @(negedge clk);
        resetn = rn; tms = t; tdi = d; dr_tdo = dt;
        @(posedge clk);
        model_step(rn, t, d);
        #1;
        in_col = (m_kind == K_COL);
        chk("tlr",        tlr,        m_kind == K_TLR);
        chk("tdo_en",     tdo_en,     in_col && m_ph == P_SH);
        chk("dr_capture", dr_capture, in_col && !m_ir && m_ph == P_CAP);
        chk("dr_shift",   dr_shift,   in_col && !m_ir && m_ph == P_SH);
        chk("dr_update",  dr_update,  in_col && !m_ir && m_ph == P_UPD);
        chk("ir_out",     ir_out,     m_out);
        chk("tdo", tdo, (in_col && m_ph == P_SH) ? (m_ir ? m_sr[0] : dt) : 1'b0);
    endtask

    task automatic tck(input logic t, input logic d);
        cyc(1'b1, t, d, 1'($urandom_range(0, 1)));
    endtask

    task automatic goto_rti();
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    logic [7:0] pat;
    logic [4:0] val;
    logic [4:0] tdo_seen;
    int n_cap, n_sh, n_upd;

    initial begin
        // Reset held for two clocks
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_tlr", tlr, 1'b1);
        chk("rst_ir", ir_out, 5'h01);

        // Five TMS=1 clocks from Shift-DR
        tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        chk("in_shdr", dr_shift, 1'b1);
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
        chk("tms5_tlr", tlr, 1'b1);
        chk("tms5_ir", ir_out, 5'h01);

        // IR load of 5'h11
        tck(1'b0, 1'b0);
        tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        val = 5'h11;
        for (int i = 0; i < 5; i++) begin
            tdo_seen[i] = tdo;
            tck(i == 4, val[i]);
        end
        chk("ir_tdo_out", tdo_seen, 5'h01);
        tck(1'b1, 1'b0);
        chk("ir_pre_upd", ir_out, 5'h01);
        tck(1'b0, 1'b0);
        chk("ir_load_11", ir_out, 5'h11);

        // 8-bit DR scan with dr_tdo pattern A5
        pat = 8'hA5; n_cap = 0; n_sh = 0; n_upd = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); n_cap += dr_capture;
        cyc(1'b1, 1'b0, 1'b0, pat[0]); n_sh += dr_shift;
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, pat[i]);
            n_sh += dr_shift;
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1); n_sh += dr_shift;
        cyc(1'b1, 1'b1, 1'b0, 1'b1); n_upd += dr_update;
        cyc(1'b1, 1'b0, 1'b0, 1'b1); n_upd += dr_update;
        chk("dr_cap_cnt", n_cap, 1);
        chk("dr_sh_cnt", n_sh, 8);
        chk("dr_upd_cnt", n_upd, 1);
        chk("ir_kept", ir_out, 5'h11);

        // IR scan paused after two bits
        val = 5'h0A;
        tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        tck(1'b0, val[0]); tck(1'b1, val[1]);
        tck(1'b0, 1'b1); tck(1'b0, 1'b1); tck(1'b0, 1'b1);
        chk("pause_ir_stable", ir_out, 5'h11);
        tck(1'b1, 1'b1); tck(1'b0, 1'b1);
        tck(1'b0, val[2]); tck(1'b0, val[3]); tck(1'b1, val[4]);
        tck(1'b1, 1'b0); tck(1'b0, 1'b0);
        chk("pause_ir_load", ir_out, 5'h0A);

        // Reset mid Shift-IR after three bits
        tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        tck(1'b0, 1'b1); tck(1'b0, 1'b1); tck(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_tlr", tlr, 1'b1);
        chk("midrst_ir", ir_out, 5'h01);
        tck(1'b0, 1'b0);
        chk("midrst_ir2", ir_out, 5'h01);

        // Random traffic, TMS biased low so scans reach deep states
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) < 4),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        goto_rti();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
